// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 instruction encoder: op selector, FSM states,
// opcode field constants and legal immediate ranges.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_ADDI  = 4'd0,
        OP_ADDS  = 4'd1,
        OP_SUBS  = 4'd2,
        OP_B     = 4'd3,
        OP_B_LT  = 4'd4,
        OP_CBZ   = 4'd5,
        OP_LDUR  = 4'd6,
        OP_LDURB = 4'd7,
        OP_STUR  = 4'd8,
        OP_STURB = 4'd9,
        OP_MOVZ  = 4'd10,
        OP_MOVK  = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_HOLD
    } state_e;

    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [7:0]  OPC_B_CND = 8'b01010100;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_LDURB = 11'b00111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_STURB = 11'b00111000000;
    localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OPC_MOVK  = 9'b111100101;

    localparam logic [4:0]  COND_LT   = 5'b01011;

    localparam int IMM12_MAX = 4095;
    localparam int IMM16_MAX = 65535;
    localparam int IMM9_MIN  = -256;
    localparam int IMM9_MAX  = 255;
    localparam int IMM19_MIN = -(1 << 18);
    localparam int IMM19_MAX = (1 << 18) - 1;
    localparam int IMM26_MIN = -(1 << 25);
    localparam int IMM26_MAX = (1 << 25) - 1;

    function automatic logic in_range(input logic signed [31:0] value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/legv8_encoder_if.sv
// Request/response port of the LEGv8 encoder: master is the loader front end,
// slave is the encoder.
interface legv8_encoder_if #(parameter int ADDR_W = 64);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [31:0]       in_imm;
    logic [1:0]        in_hw;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic              err_flag;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_hw, out_ready,
        input  in_ready, out_valid, out_word, out_addr, err, err_flag
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_hw, out_ready,
        output in_ready, out_valid, out_word, out_addr, err, err_flag
    );

endinterface

// File: rtl/legv8_pack.sv
// Combinational field packer: builds the 32-bit LEGv8 word for one request and
// flags illegal ops or out-of-range immediates.
module legv8_pack
    import legv8_pkg::*;
(
    input  logic [3:0]         op,
    input  logic [4:0]         rd,
    input  logic [4:0]         rn,
    input  logic [4:0]         rm,
    input  logic signed [31:0] imm,
    input  logic [1:0]         hw,
    output logic [31:0]        word,
    output logic               illegal
);

    op_e op_sel;

    assign op_sel = op_e'(op);

    // Fields an op does not use stay zero because each arm builds the full word.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel)
            OP_ADDI: begin
                illegal = !in_range(imm, 0, IMM12_MAX);
                word    = {OPC_ADDI, imm[11:0], rn, rd};
            end
            OP_ADDS: word = {OPC_ADDS, rm, 6'b0, rn, rd};
            OP_SUBS: word = {OPC_SUBS, rm, 6'b0, rn, rd};
            OP_B: begin
                illegal = !in_range(imm, IMM26_MIN, IMM26_MAX);
                word    = {OPC_B, imm[25:0]};
            end
            OP_B_LT: begin
                illegal = !in_range(imm, IMM19_MIN, IMM19_MAX);
                word    = {OPC_B_CND, imm[18:0], COND_LT};
            end
            OP_CBZ: begin
                illegal = !in_range(imm, IMM19_MIN, IMM19_MAX);
                word    = {OPC_CBZ, imm[18:0], rd};
            end
            OP_LDUR, OP_LDURB, OP_STUR, OP_STURB: begin
                illegal = !in_range(imm, IMM9_MIN, IMM9_MAX);
                case (op_sel)
                    OP_LDUR:  word = {OPC_LDUR,  imm[8:0], 2'b00, rn, rd};
                    OP_LDURB: word = {OPC_LDURB, imm[8:0], 2'b00, rn, rd};
                    OP_STUR:  word = {OPC_STUR,  imm[8:0], 2'b00, rn, rd};
                    default:  word = {OPC_STURB, imm[8:0], 2'b00, rn, rd};
                endcase
            end
            OP_MOVZ, OP_MOVK: begin
                illegal = !in_range(imm, 0, IMM16_MAX);
                word    = {(op_sel == OP_MOVZ) ? OPC_MOVZ : OPC_MOVK, hw, imm[15:0], rd};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_encoder.sv
// LEGv8 instruction encoder: accepts one request, encodes it, and offers the word
// with an auto-incrementing byte address until the consumer takes it.
module legv8_encoder
    import legv8_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    legv8_encoder_if.slave  bus
);

    state_e             state;
    state_e             next_state;

    logic [3:0]         req_op;
    logic [4:0]         req_rd;
    logic [4:0]         req_rn;
    logic [4:0]         req_rm;
    logic signed [31:0] req_imm;
    logic [1:0]         req_hw;

    logic [31:0]        packed_word;
    logic               illegal;

    logic [31:0]        word_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               err_q;
    logic               err_flag_q;

    legv8_pack u_pack (
        .op      (req_op),
        .rd      (req_rd),
        .rn      (req_rn),
        .rm      (req_rm),
        .imm     (req_imm),
        .hw      (req_hw),
        .word    (packed_word),
        .illegal (illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // clear wins over every handshake, dropping any word still waiting in HOLD.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) next_state = ST_ENC;
                ST_ENC:  next_state = illegal ? ST_IDLE : ST_HOLD;
                ST_HOLD: if (bus.out_ready) next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_op  <= '0;
            req_rd  <= '0;
            req_rn  <= '0;
            req_rm  <= '0;
            req_imm <= '0;
            req_hw  <= '0;
        end else if (!clear && state == ST_IDLE && bus.in_valid) begin
            req_op  <= bus.in_op;
            req_rd  <= bus.in_rd;
            req_rn  <= bus.in_rn;
            req_rm  <= bus.in_rm;
            req_imm <= bus.in_imm;
            req_hw  <= bus.in_hw;
        end
    end

    // The address only moves on a completed transfer, so rejected requests leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q     <= '0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else if (clear) begin
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            err_q <= (state == ST_ENC) && illegal;
            if (state == ST_ENC && illegal) begin
                err_flag_q <= 1'b1;
            end
            if (state == ST_ENC && !illegal) begin
                word_q <= packed_word;
            end
            if (state == ST_HOLD && bus.out_ready) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
        end
    end

    assign bus.out_word = word_q;
    assign bus.out_addr = addr_q;
    assign bus.err      = err_q;
    assign bus.err_flag = err_flag_q;

endmodule

// File: doc/legv8_encoder.md
# legv8_encoder

Instruction encoder for the single-cycle LEGv8 CPU: packs an operation selector plus operand fields into 32-bit machine words for the subset the control decoder executes (ADDI, ADDS, SUBS, B, B.LT, CBZ, LDUR, LDURB, STUR, STURB, MOVZ, MOVK). Sits between a test/loader front end and instruction-memory initialisation. Each encoded word is emitted over a valid/ready write port with an auto-incrementing byte address. Operands out of range are rejected with an error pulse.

## Interface
- ADDR_W, 64: width of the instruction byte address.
- BASE_ADDR, 0: address of the first word after reset or clear; must be a multiple of 4.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous: state to IDLE, address to BASE_ADDR, err_flag to 0; overrides all other inputs.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  4  op selector: 0 ADDI, 1 ADDS, 2 SUBS, 3 B, 4 B_LT, 5 CBZ, 6 LDUR, 7 LDURB, 8 STUR, 9 STURB, 10 MOVZ, 11 MOVK; 12-15 illegal.
- in_rd, in_rn, in_rm  in  5 each  register fields. in_rd is Rd/Rt.
- in_imm  in  32  signed two's-complement immediate. Branch offsets are in instructions, not bytes.
- in_hw  in  2  MOVZ/MOVK shift selector (LSL 16*hw).
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes word when out_valid & out_ready.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address for out_word.
- err  out  1  one-cycle pulse: request rejected.
- err_flag  out  1  sticky error. Cleared only by reset or clear.

## Operation
- FSM states:
  - IDLE: in_ready=1. On accept, register all inputs and go to ENC.
  - ENC: decode the op, check range, compute the word.
    - Legal: register out_word, go to HOLD.
    - Illegal: pulse err, set err_flag, go to IDLE. Address unchanged.
  - HOLD: out_valid=1. On out_ready, address += 4 (wraps modulo 2^ADDR_W), go to IDLE.
- Encodings (bit fields):
  - ADDI: [31:22]=1001000100, imm12[21:10], Rn[9:5], Rd[4:0].
  - ADDS/SUBS: [31:21]=10101011000 / 11101011000, Rm[20:16], [15:10]=0, Rn, Rd.
  - B: [31:26]=000101, imm26.
  - B_LT: [31:24]=01010100, imm19[23:5], cond[4:0]=01011.
  - CBZ: [31:24]=10110100, imm19[23:5], Rt[4:0].
  - LDUR/LDURB/STUR/STURB: [31:21]=11111000010 / 00111000010 / 11111000000 / 00111000000, imm9[20:12], [11:10]=00, Rn, Rt.
  - MOVZ/MOVK: [31:23]=110100101 / 111100101, hw[22:21], imm16[20:5], Rd.
- Legal immediate ranges; anything outside is an error:
  - ADDI: 0..4095.
  - MOVZ/MOVK: 0..65535.
  - Memory ops: -256..255.
  - B_LT/CBZ: -2^18..2^18-1.
  - B: -2^25..2^25-1.
- Fields an op does not use are ignored and encoded as 0.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_word=0, out_addr=BASE_ADDR, err=0, err_flag=0.
- Reset is asynchronous in every state. A word pending in HOLD is discarded.
- Latency: accept at edge k → out_valid high after edge k+1. Error case: err high for cycle k+1 only.
- Throughput: at most one word per 3 cycles. in_ready is low in ENC and HOLD.
- In HOLD, out_word and out_addr stay stable until consumed. out_valid never drops without handshake, except on reset or clear.
- clear together with a pending HOLD: the word is dropped and the address goes to BASE_ADDR.

## Structure
- Package legv8_pkg holds:
  - the op selector enum;
  - the opcode-field constants above;
  - the LT cond code;
  - immediate range limits.
- One sub-module, legv8_pack: combinational field packer plus range check (op, fields → word, illegal). The FSM and address counter stay in the top.

## Test plan
- ADDI rd=1 rn=2 imm=5 after reset → out_word 0x91001441, out_addr 0; next ADDS rd=3 rn=1 rm=2 → 0xAB020023 at addr 4; SUBS same operands → 0xEB020023 at addr 8.
- LDUR rt=0 rn=1 imm=-8 → 0xF85F8020; B imm=-1 → 0x17FFFFFF; B_LT imm=2 → 0x5400004B; CBZ rt=4 imm=3 → 0xB4000064; MOVZ rd=5 imm=0x1234 hw=1 → 0xD2A24685.
- ADDI imm=4096, then op=13 → err pulse one cycle after each accept, err_flag=1, no out_valid, next legal word still at the unchanged address.
- Hold out_ready low 5 cycles in HOLD → out_valid, out_word, out_addr constant and in_ready=0; raise out_ready → one transfer, address +4.
- Assert reset during HOLD → out_valid=0 immediately, out_addr=BASE_ADDR. Set out_addr to 2^ADDR_W-4, then transfer one word → address wraps to 0. Assert clear → err_flag=0, out_addr=BASE_ADDR.
